// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory read at a time,
// queues returned words with their PCs in a small FIFO, and hands them to
// decode in program order. A redirect flushes the queue and restarts
// fetching at the new (word-aligned) target. Any response still in flight
// when the redirect arrives is dropped.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // REQ: free to issue, WAIT: one request outstanding whose data we keep,
  // DRAIN: one request outstanding whose data must be thrown away.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  req_pc;
  logic [ADDR_WIDTH-1:0]  redirect_target;

  logic [ADDR_WIDTH-1:0]  fifo_pc   [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       fifo_count;

  logic fifo_empty;
  logic fifo_full;
  logic req_fire;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Redirect targets are forced onto a 4-byte boundary.
  assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_COUNT);

  assign imem_req_addr = fetch_pc;

  // Decode never sees an entry during reset or in a cycle being flushed.
  assign instr_valid = !fifo_empty && !redirect_valid && !reset;
  assign pop         = instr_valid && instr_ready;
  assign instr       = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  // Next-state logic, request strobe and FIFO push decision.
  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    req_fire       = 1'b0;
    push           = 1'b0;
    unique case (state)
      S_REQ: begin
        imem_req_valid = !fifo_full && !redirect_valid && !reset;
        req_fire       = imem_req_valid && imem_req_ready;
        if (req_fire) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          push       = !redirect_valid && !fifo_full;
          state_next = S_REQ;
        end else if (redirect_valid) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_resp_valid) begin
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Fetch PC tracks redirects and advances by one word per accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (req_fire) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; pairs each returned word with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= req_pc;
      fifo_data[wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a random run,
// all compared against a queue-based reference model of the fetch stream.
module tb_fetch_unit;

  localparam int          DEPTH   = 2;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  logic        w_reset;
  logic        w_redirect_valid;
  logic [63:0] w_redirect_pc;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [63:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [31:0] w_instr;
  logic [63:0] w_instr_pc;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk             (clk),
    .reset           (w_reset),
    .redirect_valid  (w_redirect_valid),
    .redirect_pc     (w_redirect_pc),
    .imem_req_valid  (w_req_valid),
    .imem_req_ready  (w_req_ready),
    .imem_req_addr   (w_req_addr),
    .imem_resp_valid (w_resp_valid),
    .imem_resp_data  (w_resp_data),
    .instr_valid     (w_instr_valid),
    .instr_ready     (w_instr_ready),
    .instr           (w_instr),
    .instr_pc        (w_instr_pc)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch address, whether a request is in flight and
  // whether its data is still wanted, plus the queue of decoded-ready words.
  logic [63:0] m_fetch_pc = '0;
  bit          m_out      = 1'b0;
  bit          m_discard  = 1'b0;
  logic [63:0] m_out_pc   = '0;
  logic [63:0] q_pc   [$];
  logic [31:0] q_data [$];

  bit          obs_req_valid;
  logic [63:0] obs_req_addr;
  bit          obs_instr_valid;
  logic [63:0] obs_instr_pc;
  logic [31:0] obs_instr;

  // Compares one cycle of DUT outputs to the model, then advances the model
  // across the rising edge. Inputs must already be driven.
  task automatic cycle(input string tag);
    bit exp_rv;
    bit exp_iv;
    #1;
    exp_rv = !reset && !m_out && (q_pc.size() < DEPTH) && !redirect_valid;
    exp_iv = !reset && (q_pc.size() > 0) && !redirect_valid;
    obs_req_valid   = imem_req_valid;
    obs_req_addr    = imem_req_addr;
    obs_instr_valid = instr_valid;
    obs_instr_pc    = instr_pc;
    obs_instr       = instr;
    checks++;
    if (imem_req_valid !== exp_rv) begin
      errors++;
      $display("[TB] FAIL %s req_valid: got %0b expected %0b", tag, imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      checks++;
      if (imem_req_addr !== m_fetch_pc) begin
        errors++;
        $display("[TB] FAIL %s req_addr: got %h expected %h", tag, imem_req_addr, m_fetch_pc);
      end
    end
    checks++;
    if (instr_valid !== exp_iv) begin
      errors++;
      $display("[TB] FAIL %s instr_valid: got %0b expected %0b", tag, instr_valid, exp_iv);
    end
    if (exp_iv) begin
      checks++;
      if (instr_pc !== q_pc[0] || instr !== q_data[0]) begin
        errors++;
        $display("[TB] FAIL %s head: got pc %h instr %h expected pc %h instr %h",
                 tag, instr_pc, instr, q_pc[0], q_data[0]);
      end
    end
    @(posedge clk);
    if (reset) begin
      m_fetch_pc = '0;
      m_out      = 1'b0;
      m_discard  = 1'b0;
      q_pc.delete();
      q_data.delete();
    end else begin
      if (exp_iv && instr_ready) begin
        void'(q_pc.pop_front());
        void'(q_data.pop_front());
      end
      if (m_out && imem_resp_valid) begin
        if (!m_discard && !redirect_valid) begin
          q_pc.push_back(m_out_pc);
          q_data.push_back(imem_resp_data);
        end
        m_out = 1'b0;
      end
      if (redirect_valid) begin
        q_pc.delete();
        q_data.delete();
        m_fetch_pc = redirect_pc & ~64'h3;
        if (m_out) m_discard = 1'b1;
      end
      if (exp_rv && imem_req_ready) begin
        m_out      = 1'b1;
        m_discard  = 1'b0;
        m_out_pc   = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
    end
    @(negedge clk);
  endtask

  // Memory that answers only requests the model knows to be in flight.
  task automatic drive_mem(input int resp_pct, input int ready_pct);
    imem_req_ready  = ($urandom_range(99) < ready_pct);
    imem_resp_valid = m_out && ($urandom_range(99) < resp_pct);
    imem_resp_data  = $urandom;
  endtask

  task automatic apply_reset();
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    instr_ready     = 1'b0;
    cycle("apply_reset");
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      reset           = 1'b1;
      redirect_valid  = $urandom_range(1);
      redirect_pc     = {$urandom, $urandom};
      imem_req_ready  = 1'b1;
      imem_resp_valid = $urandom_range(1);
      imem_resp_data  = $urandom;
      instr_ready     = $urandom_range(1);
      cycle("reset_hold");
    end
    reset           = 1'b0;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b0;
    cycle("reset_release");
    checks++;
    if (obs_req_valid !== 1'b1 || obs_req_addr !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_first_req: got valid %0b addr %h expected 1 0", obs_req_valid, obs_req_addr);
    end
  endtask

  task automatic test_streaming();
    int first_valid = -1;
    logic [63:0] popped [$];
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      drive_mem(100, 100);
      cycle("stream");
      if (obs_instr_valid && first_valid < 0) first_valid = k;
      if (obs_instr_valid) popped.push_back(obs_instr_pc);
    end
    checks++;
    if (first_valid != 2) begin
      errors++;
      $display("[TB] FAIL stream_latency: got %0d expected 2", first_valid);
    end
    checks++;
    if (popped.size() < 3 || popped[0] !== 64'h0 || popped[1] !== 64'h4 || popped[2] !== 64'h8) begin
      errors++;
      $display("[TB] FAIL stream_order: got %0d entries, expected 0,4,8 first", popped.size());
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] popped [$];
    bit seen_req = 1'b0;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      instr_ready = 1'b0;
      drive_mem(100, 100);
      cycle("bp_stall");
    end
    checks++;
    if (obs_req_valid !== 1'b0 || obs_instr_valid !== 1'b1 || obs_instr_pc !== 64'h0) begin
      errors++;
      $display("[TB] FAIL bp_full: got req %0b valid %0b pc %h expected 0 1 0",
               obs_req_valid, obs_instr_valid, obs_instr_pc);
    end
    for (int k = 0; k < 10; k++) begin
      instr_ready = 1'b1;
      drive_mem(100, 100);
      cycle("bp_resume");
      if (obs_instr_valid) popped.push_back(obs_instr_pc);
      if (obs_req_valid && !seen_req) begin
        seen_req = 1'b1;
        checks++;
        if (obs_req_addr !== 64'h8) begin
          errors++;
          $display("[TB] FAIL bp_resume_addr: got %h expected 8", obs_req_addr);
        end
      end
    end
    checks++;
    if (popped.size() < 3 || popped[0] !== 64'h0 || popped[1] !== 64'h4 || popped[2] !== 64'h8) begin
      errors++;
      $display("[TB] FAIL bp_order: got %0d entries, expected 0,4,8 first", popped.size());
    end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] good_word;
    apply_reset();
    instr_ready     = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    cycle("rw_handshake");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    cycle("rw_redirect");
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    cycle("rw_stale");
    checks++;
    if (obs_req_valid !== 1'b0 || obs_instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rw_drain: got req %0b valid %0b expected 0 0", obs_req_valid, obs_instr_valid);
    end
    imem_resp_valid = 1'b0;
    cycle("rw_newreq");
    checks++;
    if (obs_req_valid !== 1'b1 || obs_req_addr !== 64'h1000) begin
      errors++;
      $display("[TB] FAIL rw_req_addr: got valid %0b addr %h expected 1 1000", obs_req_valid, obs_req_addr);
    end
    good_word       = $urandom;
    imem_resp_valid = 1'b1;
    imem_resp_data  = good_word;
    cycle("rw_resp");
    imem_resp_valid = 1'b0;
    cycle("rw_deliver");
    checks++;
    if (obs_instr_valid !== 1'b1 || obs_instr_pc !== 64'h1000 || obs_instr !== good_word) begin
      errors++;
      $display("[TB] FAIL rw_instr: got valid %0b pc %h instr %h expected 1 1000 %h",
               obs_instr_valid, obs_instr_pc, obs_instr, good_word);
    end
  endtask

  task automatic test_redirect_with_resp();
    apply_reset();
    instr_ready     = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    cycle("rr_req0");
    imem_resp_valid = 1'b1;
    imem_resp_data  = $urandom;
    cycle("rr_resp0");
    imem_resp_valid = 1'b0;
    cycle("rr_req4");
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h2000;
    imem_resp_valid = 1'b1;
    imem_resp_data  = $urandom;
    cycle("rr_redirect");
    checks++;
    if (obs_instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rr_valid_during: got %0b expected 0", obs_instr_valid);
    end
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    cycle("rr_after");
    checks++;
    if (obs_instr_valid !== 1'b0 || obs_req_valid !== 1'b1 || obs_req_addr !== 64'h2000) begin
      errors++;
      $display("[TB] FAIL rr_after: got valid %0b req %0b addr %h expected 0 1 2000",
               obs_instr_valid, obs_req_valid, obs_req_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    instr_ready     = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    cycle("rst_wait_req");
    reset = 1'b1;
    cycle("rst_wait_reset");
    reset           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    cycle("rst_wait_stale");
    checks++;
    if (obs_req_valid !== 1'b1 || obs_req_addr !== 64'h0 || obs_instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_stale: got req %0b addr %h valid %0b expected 1 0 0",
               obs_req_valid, obs_req_addr, obs_instr_valid);
    end
    imem_resp_valid = 1'b0;
    cycle("rst_wait_after");
    checks++;
    if (obs_instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_no_push: got %0b expected 0", obs_instr_valid);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      reset          = ($urandom_range(99) < 2);
      redirect_valid = ($urandom_range(99) < 10);
      redirect_pc    = {$urandom, $urandom};
      instr_ready    = ($urandom_range(99) < 60);
      drive_mem(60, 70);
      cycle("random");
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] word;
    w_reset          = 1'b1;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_req_ready      = 1'b0;
    w_resp_valid     = 1'b0;
    w_resp_data      = '0;
    w_instr_ready    = 1'b0;
    #1;
    checks++;
    if (w_req_valid !== 1'b0 || w_instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_in_reset: got req %0b valid %0b expected 0 0", w_req_valid, w_instr_valid);
    end
    @(posedge clk);
    @(negedge clk);
    w_reset     = 1'b0;
    w_req_ready = 1'b1;
    #1;
    checks++;
    if (w_req_valid !== 1'b1 || w_req_addr !== WRAP_PC) begin
      errors++;
      $display("[TB] FAIL wrap_first: got valid %0b addr %h expected 1 %h", w_req_valid, w_req_addr, WRAP_PC);
    end
    @(posedge clk);
    @(negedge clk);
    word         = $urandom;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b1;
    w_resp_data  = word;
    @(posedge clk);
    @(negedge clk);
    w_resp_valid = 1'b0;
    #1;
    checks++;
    if (w_req_valid !== 1'b1 || w_req_addr !== 64'h0) begin
      errors++;
      $display("[TB] FAIL wrap_second: got valid %0b addr %h expected 1 0", w_req_valid, w_req_addr);
    end
    checks++;
    if (w_instr_valid !== 1'b1 || w_instr_pc !== WRAP_PC || w_instr !== word) begin
      errors++;
      $display("[TB] FAIL wrap_instr: got valid %0b pc %h instr %h expected 1 %h %h",
               w_instr_valid, w_instr_pc, w_instr, WRAP_PC, word);
    end
  endtask

  initial begin
    reset            = 1'b1;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    imem_req_ready   = 1'b0;
    imem_resp_valid  = 1'b0;
    imem_resp_data   = '0;
    instr_ready      = 1'b0;
    w_reset          = 1'b1;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_req_ready      = 1'b0;
    w_resp_valid     = 1'b0;
    w_resp_data      = '0;
    w_instr_ready    = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_wait();
    test_redirect_with_resp();
    test_reset_in_wait();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, SHALL set the width of the PC and instruction-memory address.
REQ-002 Parameter INSTR_WIDTH, default 32, SHALL set the width of the fetched instruction word.
REQ-003 Parameter RESET_PC, default 64'h0, SHALL set the PC loaded on reset.
REQ-004 Parameter FIFO_DEPTH, default 2, SHALL set the number of entries in the fetch buffer.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  SHALL be synchronous and active-high.
REQ-007 redirect_valid  in  1  SHALL request a fetch restart at redirect_pc (branch, jump or trap).
REQ-008 redirect_pc  in  ADDR_WIDTH  SHALL be the new fetch target.
REQ-009 imem_req_valid  out  1  SHALL indicate a valid instruction-memory read request.
REQ-010 imem_req_ready  in  1  SHALL indicate the memory accepts the request this cycle.
REQ-011 imem_req_addr  out  ADDR_WIDTH  SHALL be the request address.
REQ-012 imem_resp_valid  in  1  SHALL indicate that imem_resp_data is valid this cycle; it carries no back-pressure.
REQ-013 imem_resp_data  in  INSTR_WIDTH  SHALL be the returned instruction word.
REQ-014 instr_valid  out  1  SHALL indicate that instr and instr_pc are valid for decode.
REQ-015 instr_ready  in  1  SHALL indicate decode consumes the head entry this cycle.
REQ-016 instr  out  INSTR_WIDTH  SHALL be the head instruction, fed directly to the decoder instr input.
REQ-017 instr_pc  out  ADDR_WIDTH  SHALL be the PC of the head instruction.

Function
REQ-018 State machine SHALL have states REQ, WAIT and DRAIN, with at most one memory request outstanding.
REQ-019 In REQ, imem_req_valid SHALL be 1 only when fifo_count < FIFO_DEPTH and redirect_valid = 0; imem_req_addr SHALL equal fetch_pc.
REQ-020 A request handshake in REQ (valid & ready) SHALL latch req_pc = fetch_pc, set fetch_pc += 4 (mod 2^ADDR_WIDTH), and move to WAIT.
REQ-021 In WAIT, imem_resp_valid SHALL push {req_pc, imem_resp_data} into the FIFO and return to REQ the next cycle; push SHALL never occur when the FIFO is full.
REQ-022 imem_resp_valid received in REQ SHALL be ignored.
REQ-023 instr_valid SHALL equal (FIFO not empty) & !redirect_valid; instr and instr_pc SHALL present the head entry.
REQ-024 instr_valid & instr_ready SHALL pop the head; a simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-025 A redirect SHALL flush all FIFO entries and set fetch_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; a pop in the same cycle SHALL be ignored.
REQ-026 Redirect in WAIT without imem_resp_valid SHALL move to DRAIN.
REQ-027 Redirect in WAIT with imem_resp_valid SHALL discard the response and move to REQ.
REQ-028 Redirect in DRAIN SHALL update fetch_pc and keep the state DRAIN.
REQ-029 In DRAIN, imem_resp_valid SHALL be discarded without a push, and the state SHALL return to REQ.
REQ-030 Minimum latency SHALL be 2 cycles: request handshake at cycle N, response at N+1, instr_valid at N+2.

Reset
REQ-031 On reset, the state SHALL be REQ, fetch_pc = RESET_PC, the FIFO empty and req_pc = 0.
REQ-032 During reset, imem_req_valid and instr_valid SHALL be 0.
REQ-033 Reset SHALL override a concurrent redirect, handshake or response.
REQ-034 A response arriving after a mid-operation reset SHALL be ignored (covered by REQ-022).

Verification
REQ-035 Reset, then memory always ready with a 1-cycle response, decode always ready -> instr_pc sequence 0x0, 0x4, 0x8, with the first instr_valid 2 cycles after the first handshake.
REQ-036 instr_ready held at 0 -> after 2 words, imem_req_valid = 0 and instr_valid = 1 with instr_pc = 0x0; instr_ready then raised -> fetch resumes at 0x8 with no loss or duplication.
REQ-037 Redirect to 0x1003 while in WAIT, response 2 cycles later -> old response dropped, next request address 0x1000, next instr_pc 0x1000.
REQ-038 Redirect in the same cycle as imem_resp_valid with the FIFO holding 1 entry -> FIFO empty, response dropped, instr_valid = 0 that cycle, next request to redirect_pc.
REQ-039 Reset asserted in WAIT, stale response the following cycle -> no push, first request address RESET_PC.
REQ-040 RESET_PC = 2^64-4 -> second request address wraps to 0x0.
